ram_arbiter_2port: RTL

//  Two-master round-robin arbiter for the single-port synchronous 8192x32 RAM.

---
 rtl/ram_arbiter_2port.sv | 90 +++++++++
 1 files changed

// File: rtl/ram_arbiter_2port.sv
// rtl/ram_arbiter_2port.sv - two-master round-robin arbiter for a single-port synchronous RAM
module ram_arbiter_2port #(
  parameter int AW = 13,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_rnw,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic          a_ack,
  output logic [DW-1:0] a_dout,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_rnw,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  output logic          b_ack,
  output logic [DW-1:0] b_dout,
  output logic          b_rvalid,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_din,
  output logic          ram_rnw,
  output logic          ram_cs_b,
  input  logic [DW-1:0] ram_dout
);

  logic          r_last_b;
  logic          r_rd_a;
  logic          r_rd_b;
  logic [DW-1:0] r_hold_a;
  logic [DW-1:0] r_hold_b;
  logic          w_gnt_a;
  logic          w_gnt_b;

  // Grants are masked by reset so the RAM stays deselected even with requests raised.
  assign w_gnt_a = ~reset & a_req & (~b_req | r_last_b);
  assign w_gnt_b = ~reset & b_req & ~w_gnt_a;

  assign a_ack = w_gnt_a;
  assign b_ack = w_gnt_b;

  always_comb begin
    ram_cs_b    = 1'b1;
    ram_rnw     = 1'b1;
    ram_address = '0;
    ram_din     = '0;
    if (w_gnt_a) begin
      ram_cs_b    = 1'b0;
      ram_rnw     = a_rnw;
      ram_address = a_addr;
      ram_din     = a_din;
    end else if (w_gnt_b) begin
      ram_cs_b    = 1'b0;
      ram_rnw     = b_rnw;
      ram_address = b_addr;
      ram_din     = b_din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_b <= 1'b1;
      r_rd_a   <= 1'b0;
      r_rd_b   <= 1'b0;
      r_hold_a <= '0;
      r_hold_b <= '0;
    end else begin
      if (w_gnt_a | w_gnt_b) begin
        r_last_b <= w_gnt_b;
      end
      r_rd_a <= w_gnt_a & a_rnw;
      r_rd_b <= w_gnt_b & b_rnw;
      // Capture the returning word so it stays visible until the next read completes.
      if (r_rd_a) begin
        r_hold_a <= ram_dout;
      end
      if (r_rd_b) begin
        r_hold_b <= ram_dout;
      end
    end
  end

  assign a_rvalid = r_rd_a;
  assign b_rvalid = r_rd_b;
  assign a_dout   = r_rd_a ? ram_dout : r_hold_a;
  assign b_dout   = r_rd_b ? ram_dout : r_hold_b;

endmodule
